fifo_stream_reader: RTL
=======================

Name: fifo_stream_reader

Overview:
- Single-clock read-side adapter for the team's async FIFO.
- Drives the FIFO read port: read enable in; registered data out, updated one cycle after an accepted read; ready/not-empty flag.
- Re-presents the FIFO contents as a valid/ready stream with full throughput, using a 2-entry output buffer.
- Also provides a synchronous flush and a delivered-beat counter. Sits in the FIFO read clock domain, between the FIFO and the downstream consumer.

Parameters:
DATA_WIDTH, 8, width of FIFO words and stream data
CNT_WIDTH, 16, width of delivered-beat counter (wraps)

Ports:
clk_i  input  1  clock, same clock as the FIFO read port
rst_i  input  1  asynchronous reset, active-high
fifo_rrdy_i  input  1  FIFO not empty; a read issued while high is accepted
fifo_dout_i  input  DATA_WIDTH  FIFO registered read data; valid the cycle after an accepted read
fifo_re_o  output  1  FIFO read enable
m_valid_o  output  1  stream data valid
m_ready_i  input  1  downstream ready
m_data_o  output  DATA_WIDTH  stream data (head of buffer)
flush_i  input  1  synchronous flush: drop buffered and in-flight words
beat_cnt_o  output  CNT_WIDTH  count of stream handshakes since reset or flush

Behaviour:
- Reset (async, active-high):
  - occ=0, pend=0, head/tail pointers=0, both buffer entries=0, beat_cnt_o=0.
  - m_valid_o=0, m_data_o=0.
  - fifo_re_o is forced 0 combinationally while rst_i=1.
- State: occ in {0,1,2} (buffered words), pend (1 bit, read accepted last cycle), 1-bit head and tail pointers into buf[2].
- Invariant: occ+pend <= 2 at all times. A bench assertion checks it.
- pop = m_valid_o & m_ready_i.
- Read issue: fifo_re_o = ~rst_i & ~flush_i & fifo_rrdy_i & ((occ + pend - pop) < 2).
  - Evaluate this in 3-bit arithmetic; no underflow is possible since pop implies occ>=1.
  - Combinational path m_ready_i -> fifo_re_o is intended.
- Capture: if pend=1, write fifo_dout_i into buf[tail] and toggle tail.
  - Next pend = fifo_re_o.
  - The FIFO holds dout between reads, so capture happens exactly once per accepted read.
- Output:
  - m_valid_o = (occ != 0).
  - m_data_o = buf[head]; it shows the stale head value (reset 0 or last popped) when not valid.
  - On pop, toggle head and increment beat_cnt_o modulo 2^CNT_WIDTH.
- Occupancy update: occ_next = occ + pend - pop.
  - Capture and pop in the same cycle leave occ unchanged.
  - With occ=0, a capture makes the word visible the next cycle; there is no same-cycle bypass.
- Latency: fifo_rrdy_i rising with occ=0 and pend=0 gives:
  - re in cycle 0;
  - capture at the end of cycle 1;
  - m_valid_o=1 in cycle 2.
- Throughput: with m_ready_i held 1 and the FIFO non-empty, one beat per cycle in steady state, with occ oscillating at 1 and pend at 1.
- Back-pressure:
  - m_ready_i=0 keeps m_valid_o and m_data_o stable until accepted. No data is dropped or reordered.
  - Reads stop once occ+pend reaches 2.
- FIFO empty: fifo_rrdy_i=0 means no re. Buffered words still drain.
- Flush (flush_i=1 for a clock edge):
  - occ, pend, head and tail go to 0; beat_cnt_o goes to 0; fifo_re_o is 0 in that cycle.
  - Data returning from a read accepted in the cycle before flush is discarded, because pend is cleared.
  - A pop coincident with flush is not counted; flush has priority.
  - Buffer contents are not cleared.
- Reset mid-operation: immediate return to reset values; in-flight FIFO data is lost, consistent with the FIFO being reset alongside.

Test Plan:
- Latency and order: reset, preload FIFO model with 0x11,0x22,0x33, m_ready_i=1 -> re in cycles 0,1,2; m_valid_o first high in cycle 2 with 0x11, then 0x22, 0x33 on consecutive cycles; beat_cnt_o=3.
- Back-pressure:
  - Stimulus: 4 words 0xA0..0xA3 with m_ready_i=0 for 10 cycles.
  - Response: exactly 2 re pulses total; m_data_o holds 0xA0 stable; occ=2.
  - Then raise m_ready_i -> A0,A1,A2,A3 delivered in order, no gaps after the first.
- Full throughput: 256 random words, m_ready_i=1 -> 256 beats in 258 cycles, beat_cnt_o=256, data matches scoreboard.
- Random stall: m_ready_i random 50%, fifo_rrdy_i random toggles, 1000 words -> scoreboard match; invariant occ+pend<=2 never violated; re never asserted while fifo_rrdy_i=0.
- Flush with read in flight: occ=1 (0x55), re accepted for 0x66, flush_i in the next cycle -> m_valid_o=0, beat_cnt_o=0, 0x66 never appears; the next FIFO word 0x77 is delivered first.
- Async reset mid-stream: assert rst_i between clock edges with occ=2 -> m_valid_o, fifo_re_o, beat_cnt_o go 0 immediately without waiting for a clock; normal operation resumes after release.

Source files
------------

// File: rtl/fifo_stream_reader.sv
// Read-side adapter for the async FIFO: turns the registered FIFO read port
// into a full-throughput valid/ready stream through a 2-entry buffer.
module fifo_stream_reader #(
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  fifo_rrdy_i,
  input  logic [DATA_WIDTH-1:0] fifo_dout_i,
  output logic                  fifo_re_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  input  logic                  flush_i,
  output logic [CNT_WIDTH-1:0]  beat_cnt_o
);

  logic [1:0]            occ;
  logic                  pend;
  logic                  head;
  logic                  tail;
  logic [DATA_WIDTH-1:0] mem [2];
  logic [CNT_WIDTH-1:0]  beat_cnt;
  logic                  pop;
  logic [2:0]            fill;

  // A slot is reserved for every read in flight, so a read is only issued
  // when the words held plus the word arriving still leave room after a pop.
  always_comb begin
    pop       = m_valid_o & m_ready_i;
    fill      = {1'b0, occ} + {2'b0, pend} - {2'b0, pop};
    fifo_re_o = ~rst_i & ~flush_i & fifo_rrdy_i & (fill < 3'd2);
  end

  assign m_valid_o  = (occ != 2'd0);
  assign m_data_o   = mem[head];
  assign beat_cnt_o = beat_cnt;

  // Flush wins over capture and pop; the buffer storage itself is left as is.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      mem[0]   <= '0;
      mem[1]   <= '0;
      beat_cnt <= '0;
    end else if (flush_i) begin
      occ      <= 2'd0;
      pend     <= 1'b0;
      head     <= 1'b0;
      tail     <= 1'b0;
      beat_cnt <= '0;
    end else begin
      if (pend) begin
        mem[tail] <= fifo_dout_i;
        tail      <= ~tail;
      end
      if (pop) begin
        head     <= ~head;
        beat_cnt <= beat_cnt + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
      end
      pend <= fifo_re_o;
      occ  <= fill[1:0];
    end
  end

endmodule
